key_encoder8to3: RTL and testbench

Debounced 8-to-3 encoder for eight active-low key lines, in the same one-hot-low format the display select decoder drives (code n = bit n low, all other bits high). It synchronises and debounces the raw lines and encodes the single pressed key into a 3-bit index. It emits press and release event pulses for the downstream display and counter logic.

---
 rtl/key_encoder8to3.sv | 114 +++++++++++
 tb/tb_key_encoder8to3.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/key_encoder8to3.sv
// key_encoder8to3: synchronises and debounces eight active-low key lines,
// encodes a single held key to a 3-bit index and emits press/release pulses.
module key_encoder8to3 #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_n,
    output logic [2:0] num,
    output logic       valid,
    output logic       press,
    output logic       release_o,
    output logic       invalid
);
    typedef enum logic [1:0] {IDLE, PRESSED, INVALID} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       s1_q, s2_q, cand_q, cand_d, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [2:0]       num_q, num_d, idx;
    logic             press_q, press_d, release_q, release_d;
    logic [3:0]       zeros;
    logic             is_none, is_single;

    always_comb begin
        zeros = 4'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!stable_q[i]) begin
                zeros = zeros + 4'd1;
                idx   = i[2:0];
            end
        end
        is_none   = stable_q == 8'hFF;
        is_single = zeros == 4'd1;
    end

    // The counter saturates at CNT_MAX; acceptance happens once the candidate
    // has been seen unchanged for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            stable_d = cand_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_single) begin
                    state_d = PRESSED;
                    num_d   = idx;
                    press_d = 1'b1;
                end else if (!is_none) begin
                    state_d = INVALID;
                end
            end
            PRESSED: begin
                if (is_none) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (!is_single || idx != num_q) begin
                    state_d   = INVALID;
                    release_d = 1'b1;
                end
            end
            default: state_d = is_none ? IDLE : INVALID;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 8'hFF;
            s2_q      <= 8'hFF;
            cand_q    <= 8'hFF;
            stable_q  <= 8'hFF;
            cnt_q     <= '0;
            state_q   <= IDLE;
            num_q     <= 3'd0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= key_n;
            s2_q      <= s1_q;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            num_q     <= num_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign num       = num_q;
    assign valid     = state_q == PRESSED;
    assign invalid   = state_q == INVALID;
    assign press     = press_q;
    assign release_o = release_q;
endmodule

// File: tb/tb_key_encoder8to3.sv
// tb_key_encoder8to3: directed scenarios; expected press/release events are
// queued at stimulus time and matched by an independent pulse monitor.
module tb_key_encoder8to3;
    localparam int DEB = 4;
    // key change driven at a negedge: s1, s2, cand load, DEB count/accept edges, FSM edge
    localparam int LAT = DEB + 4;

    typedef struct {
        bit         rel;
        logic [2:0] n;
        int         at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key_n;
    logic [2:0] num;
    logic       valid, press, release_o, invalid;

    ev_t q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;

    key_encoder8to3 #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .num(num), .valid(valid),
        .press(press), .release_o(release_o), .invalid(invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && (press || release_o)) begin
            vectors++;
            if (press && release_o) begin
                miscompares++;
                $display("FAIL pulse_overlap: press=1 release=1 at cycle %0d, required at most one", cyc);
            end else if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: press=%0b release=%0b num=%0d at cycle %0d, required none",
                         press, release_o, num, cyc);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.rel != release_o || e.at != cyc || (!e.rel && num != e.n)) begin
                    miscompares++;
                    $display("FAIL event: got release=%0b num=%0d cycle=%0d, required release=%0b num=%0d cycle=%0d",
                             release_o, num, cyc, e.rel, e.n, e.at);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v, input bit expect_ev, input bit rel, input logic [2:0] n);
        key_n = v;
        if (expect_ev) q.push_back('{rel, n, cyc + LAT});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 8'hFF;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(3);
        // 1: asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", {3'b0, num, valid, press, release_o, invalid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(10);
        // 2: clean press and release of key 2
        drive(8'hFB, 1, 0, 3'd2);
        wait_cycles(20);
        chk("press2_num", {5'b0, num}, 8'd2);
        chk("press2_valid", {7'b0, valid}, 8'd1);
        drive(8'hFF, 1, 1, 3'd0);
        wait_cycles(20);
        chk("rel2_valid", {7'b0, valid}, 8'd0);
        chk("rel2_num_hold", {5'b0, num}, 8'd2);
        // 3: bounce, then a settled press timed from the last transition
        for (int i = 0; i < 6; i++) begin
            key_n = (i % 2 == 0) ? 8'hFB : 8'hFF;
            wait_cycles(2);
        end
        drive(8'hFB, 1, 0, 3'd2);
        wait_cycles(20);
        chk("bounce_num", {5'b0, num}, 8'd2);
        chk("bounce_valid", {7'b0, valid}, 8'd1);
        drive(8'hFF, 1, 1, 3'd0);
        wait_cycles(20);
        // 4: illegal pattern from IDLE, checked on both sides of the latency edge
        drive(8'hF6, 0, 0, 3'd0);
        wait_cycles(LAT - 1);
        chk("illegal_before", {7'b0, invalid}, 8'd0);
        wait_cycles(1);
        chk("illegal_at", {7'b0, invalid}, 8'd1);
        wait_cycles(5);
        chk("illegal_num", {5'b0, num}, 8'd2);
        chk("illegal_valid", {7'b0, valid}, 8'd0);
        drive(8'hFF, 0, 0, 3'd0);
        wait_cycles(20);
        chk("illegal_clear", {7'b0, invalid}, 8'd0);
        // 5: direct key change while pressed
        drive(8'h7F, 1, 0, 3'd7);
        wait_cycles(20);
        chk("press7_num", {5'b0, num}, 8'd7);
        chk("press7_valid", {7'b0, valid}, 8'd1);
        drive(8'hFE, 1, 1, 3'd0);
        wait_cycles(20);
        chk("change_invalid", {7'b0, invalid}, 8'd1);
        chk("change_valid", {7'b0, valid}, 8'd0);
        chk("change_num", {5'b0, num}, 8'd7);
        drive(8'hFF, 0, 0, 3'd0);
        wait_cycles(20);
        chk("change_idle", {6'b0, valid, invalid}, 8'd0);
        // 6: reset while key 4 is held, then re-press after full latency
        drive(8'hEF, 1, 0, 3'd4);
        wait_cycles(20);
        chk("press4_valid", {7'b0, valid}, 8'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midreset_outputs", {3'b0, num, valid, press, release_o, invalid}, 8'h00);
        wait_cycles(3);
        rst_n = 1'b1;
        q.push_back('{1'b0, 3'd4, cyc + LAT});
        wait_cycles(20);
        chk("repress4_num", {5'b0, num}, 8'd4);
        chk("repress4_valid", {7'b0, valid}, 8'd1);
        drive(8'hFF, 1, 1, 3'd0);
        wait_cycles(20);
        chk("pending_events", 8'(q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
